// File: rtl/muldiv_seq_ctrl.sv
// Iterative radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU.
// Accepts one operation per start, stalls the pipeline until done pulses.
module muldiv_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_signed,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             rem_sel;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] result_q;

    logic             idle;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        idle     = (state == S_IDLE) || (state == S_DONE);
        div_zero = (b == '0);
        ovf      = op_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        abs_a    = (op_signed && a[WIDTH-1]) ? ('0 - a) : a;
        abs_b    = (op_signed && b[WIDTH-1]) ? ('0 - b) : b;
        // Borrow out of the trial subtraction lands in diff[WIDTH].
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, div};
        quo_fix  = neg_q ? ('0 - quo) : quo;
        rem_fix  = neg_r ? ('0 - rem) : rem;
    end

    assign busy   = (state == S_ITER) || (state == S_FIX);
    assign done   = (state == S_DONE);
    assign stall  = busy | (start & idle & ~flush);
    assign result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            rem_sel  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            div      <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_ITER: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result_q <= rem_sel ? rem_fix : quo_fix;
                    state    <= S_DONE;
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (start) begin
                        rem_sel <= op_rem;
                        neg_q   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !div_zero;
                        neg_r   <= op_signed && a[WIDTH-1];
                        quo     <= abs_a;
                        div     <= abs_b;
                        rem     <= '0;
                        count   <= '0;
                        if (div_zero) begin
                            result_q <= op_rem ? a : '1;
                            state    <= S_DONE;
                        end else if (ovf) begin
                            result_q <= op_rem ? '0 : a;
                            state    <= S_DONE;
                        end else begin
                            state <= S_ITER;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: vector table plus multi-cycle sequences.
module tb_muldiv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_signed;
    logic        op_rem;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    muldiv_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_signed (op_signed),
        .op_rem    (op_rem),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[20];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        bit got;
        int cyc;
        int busy_err;
        got      = 0;
        cyc      = 0;
        busy_err = 0;
        tick();
        start = 1'b1; op_signed = v.sgn; op_rem = v.rem; a = v.a; b = v.b;
        mid();
        check({nm, " stall_c0"}, {31'd0, stall}, 32'd1);
        check({nm, " busy_c0"}, {31'd0, busy}, 32'd0);
        tick();
        // Operand changes after capture must not matter.
        start = 1'b0; a = $urandom; b = $urandom; op_signed = ~v.sgn; op_rem = ~v.rem;
        for (int c = 1; c <= 60; c++) begin
            mid();
            if (done === 1'b1) begin
                got = 1;
                cyc = c;
                break;
            end
            if (busy !== (v.lat > 1)) busy_err++;
            tick();
        end
        check({nm, " latency"}, got ? cyc : 0, v.lat);
        check({nm, " result"}, result, v.exp);
        check({nm, " busy_pattern_errs"}, busy_err, 0);
        if (got) last_res = v.exp;
    endtask

    initial begin
        int          dn;
        int          d_cyc[$];
        logic [31:0] d_res[$];

        vecs[0]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        34};
        vecs[1]  = '{1'b1, 1'b1, 32'd100,       32'd7,         32'd2,         34};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  34};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  34};
        vecs[4]  = '{1'b0, 1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  34};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFFFFF9,  32'd2,         32'd1,         34};
        vecs[6]  = '{1'b1, 1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  1};
        vecs[7]  = '{1'b0, 1'b1, 32'h12345678,  32'd0,         32'h12345678,  1};
        vecs[8]  = '{1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
        vecs[9]  = '{1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1};
        vecs[10] = '{1'b1, 1'b0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  34};
        vecs[11] = '{1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  32'd1,         34};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         34};
        vecs[13] = '{1'b1, 1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF,  34};
        vecs[14] = '{1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         34};
        vecs[15] = '{1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  34};
        vecs[16] = '{1'b1, 1'b1, 32'hFFFFFFF8,  32'd0,         32'hFFFFFFF8,  1};
        vecs[17] = '{1'b1, 1'b0, 32'h80000000,  32'd1,         32'h80000000,  34};
        vecs[18] = '{1'b0, 1'b0, 32'd0,         32'd5,         32'd0,         34};
        vecs[19] = '{1'b0, 1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  34};

        rst = 1'b1; start = 1'b0; op_signed = 1'b0; op_rem = 1'b0;
        a = '0; b = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mid();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset result", result, 32'd0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Flush mid-ITER at cycle 10, restart at cycle 12.
        dn = 0;
        tick();
        start = 1'b1; op_signed = 1'b1; op_rem = 1'b0; a = 32'd50; b = 32'd5;
        mid();
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            mid();
            if (done === 1'b1) dn++;
        end
        tick();
        flush = 1'b1;
        mid();
        check("flush c10 busy", {31'd0, busy}, 32'd1);
        tick();
        flush = 1'b0;
        mid();
        check("flush c11 busy", {31'd0, busy}, 32'd0);
        check("flush c11 done", {31'd0, done}, 32'd0);
        check("flush c11 result held", result, last_res);
        check("flush no done 1..10", dn, 0);
        run_op('{1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 34}, "after_flush");

        // Flush and start together: nothing captured.
        tick();
        start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd3;
        mid();
        check("flush+start stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        mid();
        check("flush+start busy", {31'd0, busy}, 32'd0);
        check("flush+start done", {31'd0, done}, 32'd0);

        // Flush in the DONE cycle of a special case.
        tick();
        start = 1'b1; op_signed = 1'b1; op_rem = 1'b0; a = 32'h12345678; b = 32'd0;
        mid();
        tick();
        flush = 1'b1; a = 32'd100; b = 32'd7;
        mid();
        check("flush@done done", {31'd0, done}, 32'd1);
        check("flush@done result", result, 32'hFFFFFFFF);
        check("flush@done stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        mid();
        check("flush@done next busy", {31'd0, busy}, 32'd0);
        dn = 0;
        for (int c = 2; c <= 40; c++) begin
            if (done === 1'b1) dn++;
            tick();
            mid();
        end
        check("flush@done no extra done", dn, 0);
        last_res = 32'hFFFFFFFF;

        // Reset asserted mid-ITER.
        tick();
        start = 1'b1; op_signed = 1'b0; op_rem = 1'b0; a = 32'd1000; b = 32'd3;
        mid();
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            mid();
        end
        tick();
        rst = 1'b1;
        mid();
        tick();
        rst = 1'b0;
        mid();
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid done", {31'd0, done}, 32'd0);
        check("rst mid stall", {31'd0, stall}, 32'd0);
        check("rst mid result", result, 32'd0);
        last_res = '0;

        // Back-to-back: ignored start at cycle 5, restart in DONE cycle 34.
        tick();
        start = 1'b1; op_signed = 1'b1; op_rem = 1'b0; a = 32'd100; b = 32'd7;
        mid();
        for (int c = 1; c <= 80; c++) begin
            tick();
            start = 1'b0;
            if (c == 5) begin
                start = 1'b1; a = 32'd1; b = 32'd1;
            end
            if (c == 34) begin
                start = 1'b1; op_signed = 1'b0; a = 32'd9; b = 32'd3;
            end
            mid();
            if (c == 5) check("b2b busy start ignored", {31'd0, busy}, 32'd1);
            if (c == 34) begin
                check("b2b c34 stall", {31'd0, stall}, 32'd1);
                check("b2b c34 busy", {31'd0, busy}, 32'd0);
            end
            if (done === 1'b1) begin
                d_cyc.push_back(c);
                d_res.push_back(result);
            end
        end
        check("b2b done count", d_cyc.size(), 2);
        if (d_cyc.size() >= 2) begin
            check("b2b first cycle", d_cyc[0], 34);
            check("b2b first result", d_res[0], 32'd14);
            check("b2b second cycle", d_cyc[1], 68);
            check("b2b second result", d_res[1], 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
